// File: rtl/ex_mem_req_if.sv
// Data-SRAM request/response bus between the EX-stage memory requester and the memory side.
// The master drives the request; the slave returns the address/data handshakes and read data.
interface ex_mem_req_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/ex_mem_req.sv
// EX-stage data-SRAM requester. It issues load/store requests and tracks outstanding accesses
// in a tag FIFO, so that returned read data can be aligned and extended.
module ex_mem_req #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic                     in_mem_en,
    input  logic [2:0]               in_st_ctrl,
    input  logic [4:0]               in_ld_ctrl,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [31:0]              in_wdata,
    input  logic                     out_allow_in,
    input  logic                     cancel,
    input  logic                     flush,
    output logic                     ready_go,
    output logic                     ale,
    ex_mem_req_if.master             data_sram,
    output logic                     resp_valid,
    output logic                     resp_is_store,
    output logic [31:0]              resp_data,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic ld_w_s, ld_bu_s, ld_b_s, ld_hu_s, ld_h_s;
    logic st_w_s, st_h_s, st_b_s;
    logic access_s, wr_s, ale_s, req_s, ready_go_s, handoff_s;
    logic full_s, empty_s, pop_s, push_s, blocked_s;
    logic [1:0]  size_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    logic [31:0] shifted_s, resp_data_s;

    logic                 hold_r;
    logic                 proto_err_r;
    logic [PTR_W-1:0]     head_r, tail_r;
    logic [PTR_W:0]       count_r;
    logic [4:0]           tag_ld_r  [DEPTH];
    logic [1:0]           tag_off_r [DEPTH];
    logic [DEPTH-1:0]     tag_wr_r;
    logic [DEPTH-1:0]     tag_disc_r;

    assign {ld_w_s, ld_bu_s, ld_b_s, ld_hu_s, ld_h_s} = in_ld_ctrl;
    assign {st_w_s, st_h_s, st_b_s}                   = in_st_ctrl;

    assign access_s = in_valid & in_mem_en;
    assign wr_s     = (|in_st_ctrl) & ~(|in_ld_ctrl);
    assign full_s   = (count_r == DEPTH_C);
    assign empty_s  = (count_r == {(PTR_W + 1){1'b0}});
    assign pop_s    = data_sram.data_ok & ~empty_s;
    // A slot freed by a same-cycle response may be refilled immediately.
    assign blocked_s = full_s & ~pop_s;
    assign req_s     = access_s & ~ale_s & out_allow_in & ~cancel & ~hold_r & ~blocked_s;
    assign push_s    = req_s & data_sram.addr_ok;
    assign handoff_s = ready_go_s & out_allow_in;

    // Request decode: misalignment, size, byte strobes, store data and stage handoff.
    always_comb begin
        ale_s      = 1'b0;
        size_s     = 2'd0;
        wstrb_s    = 4'b0000;
        wdata_s    = in_wdata;
        ready_go_s = 1'b1;

        if (in_valid) begin
            ale_s = ((ld_h_s | ld_hu_s | st_h_s) & in_addr[0]) |
                    ((ld_w_s | st_w_s) & (in_addr[1:0] != 2'b00));
        end else begin
            ale_s = 1'b0;
        end

        if (ld_w_s | st_w_s) begin
            size_s = 2'd2;
        end else if (ld_h_s | ld_hu_s | st_h_s) begin
            size_s = 2'd1;
        end else begin
            size_s = 2'd0;
        end

        if (!in_valid || !wr_s) begin
            wstrb_s = 4'b0000;
        end else if (st_w_s) begin
            wstrb_s = 4'b1111;
        end else if (st_h_s) begin
            wstrb_s = in_addr[1] ? 4'b1100 : 4'b0011;
        end else if (st_b_s) begin
            wstrb_s = 4'b0001 << in_addr[1:0];
        end else begin
            wstrb_s = 4'b0000;
        end

        if (st_b_s) begin
            wdata_s = {4{in_wdata[7:0]}};
        end else if (st_h_s) begin
            wdata_s = {2{in_wdata[15:0]}};
        end else begin
            wdata_s = in_wdata;
        end

        if (req_s) begin
            ready_go_s = data_sram.addr_ok;
        end else if (access_s & ~cancel & ~hold_r & ~ale_s & out_allow_in & blocked_s) begin
            ready_go_s = 1'b0;
        end else begin
            ready_go_s = 1'b1;
        end
    end

    // Response formatting: align the head entry's bytes and extend per load type.
    always_comb begin
        shifted_s   = data_sram.rdata >> {tag_off_r[head_r], 3'b000};
        resp_data_s = 32'h0000_0000;
        if (tag_wr_r[head_r]) begin
            resp_data_s = 32'h0000_0000;
        end else if (tag_ld_r[head_r][2]) begin
            resp_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end else if (tag_ld_r[head_r][3]) begin
            resp_data_s = {24'h00_0000, shifted_s[7:0]};
        end else if (tag_ld_r[head_r][0]) begin
            resp_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end else if (tag_ld_r[head_r][1]) begin
            resp_data_s = {16'h0000, shifted_s[15:0]};
        end else if (tag_ld_r[head_r][4]) begin
            resp_data_s = data_sram.rdata;
        end else begin
            resp_data_s = 32'h0000_0000;
        end
    end

    // Sticky hold: a cancelled instruction that cannot hand off stays suppressed until it leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r <= 1'b0;
        end else if (handoff_s) begin
            hold_r <= 1'b0;
        end else if (cancel) begin
            hold_r <= 1'b1;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Outstanding-request tag FIFO with flush marking and the protocol-error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W + 1){1'b0}};
            tag_wr_r    <= {DEPTH{1'b0}};
            tag_disc_r  <= {DEPTH{1'b0}};
            proto_err_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_ld_r[i]  <= 5'd0;
                tag_off_r[i] <= 2'd0;
            end
        end else begin
            if (flush) begin
                tag_disc_r <= {DEPTH{1'b1}};
            end
            if (push_s) begin
                tag_ld_r[tail_r]   <= in_ld_ctrl;
                tag_off_r[tail_r]  <= in_addr[1:0];
                tag_wr_r[tail_r]   <= wr_s;
                tag_disc_r[tail_r] <= flush;
                tail_r             <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (data_sram.data_ok && empty_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign ale             = ale_s;
    assign ready_go        = ready_go_s;
    assign data_sram.req   = req_s;
    assign data_sram.wr    = wr_s;
    assign data_sram.size  = size_s;
    assign data_sram.addr  = in_addr;
    assign data_sram.wstrb = wstrb_s;
    assign data_sram.wdata = wdata_s;
    assign resp_valid      = pop_s & ~tag_disc_r[head_r] & ~flush;
    assign resp_is_store   = ~empty_s & tag_wr_r[head_r];
    assign resp_data       = resp_data_s;
    assign outstanding     = count_r;
    assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed bench for ex_mem_req: fixed vectors with hand-computed expected values.
module tb_ex_mem_req;
    logic        clk;
    logic        resetn;
    logic        in_valid, in_mem_en;
    logic [2:0]  in_st_ctrl;
    logic [4:0]  in_ld_ctrl;
    logic [31:0] in_addr, in_wdata;
    logic        out_allow_in, cancel, flush;
    logic        ready_go, ale;
    logic        resp_valid, resp_is_store;
    logic [31:0] resp_data;
    logic [1:0]  outstanding;
    logic        proto_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [4:0] LD_W = 5'b10000, LD_BU = 5'b01000, LD_B = 5'b00100,
                           LD_HU = 5'b00010, LD_H = 5'b00001;
    localparam logic [2:0] ST_H = 3'b010, ST_B = 3'b001;

    ex_mem_req_if #(.ADDR_W(32)) sram_if ();

    ex_mem_req #(.ADDR_W(32), .DEPTH(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_mem_en     (in_mem_en),
        .in_st_ctrl    (in_st_ctrl),
        .in_ld_ctrl    (in_ld_ctrl),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .out_allow_in  (out_allow_in),
        .cancel        (cancel),
        .flush         (flush),
        .ready_go      (ready_go),
        .ale           (ale),
        .data_sram     (sram_if),
        .resp_valid    (resp_valid),
        .resp_is_store (resp_is_store),
        .resp_data     (resp_data),
        .outstanding   (outstanding),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] ld, input logic [2:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        in_valid   = 1'b1;
        in_mem_en  = 1'b1;
        in_ld_ctrl = ld;
        in_st_ctrl = st;
        in_addr    = a;
        in_wdata   = wd;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_mem_en  = 1'b0;
        in_ld_ctrl = 5'd0;
        in_st_ctrl = 3'd0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        in_addr = 32'h0; in_wdata = 32'h0;
        out_allow_in = 1'b0; cancel = 1'b0; flush = 1'b0;
        sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b0; sram_if.rdata = 32'h0;
        repeat (2) tick();
        check("rst_req", {31'd0, sram_if.req}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_outstanding", {30'd0, outstanding}, 32'd0);
        check("rst_ready_go", {31'd0, ready_go}, 32'd1);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        resetn = 1'b1;
        out_allow_in = 1'b1;
        tick();

        // Signed byte load at offset 3
        drive(LD_B, 3'd0, 32'h0000_1003, 32'h0);
        #1;
        check("ldb_req", {31'd0, sram_if.req}, 32'd1);
        check("ldb_size", {30'd0, sram_if.size}, 32'd0);
        check("ldb_wr", {31'd0, sram_if.wr}, 32'd0);
        check("ldb_wstrb", {28'd0, sram_if.wstrb}, 32'd0);
        check("ldb_rg_wait", {31'd0, ready_go}, 32'd0);
        sram_if.addr_ok = 1'b1; #1;
        check("ldb_rg_ok", {31'd0, ready_go}, 32'd1);
        tick();
        idle(); sram_if.addr_ok = 1'b0; #1;
        check("ldb_outstanding", {30'd0, outstanding}, 32'd1);
        sram_if.data_ok = 1'b1; sram_if.rdata = 32'h80FF_0000; #1;
        check("ldb_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("ldb_resp_data", resp_data, 32'hFFFF_FF80);
        tick();
        sram_if.data_ok = 1'b0; #1;
        check("ldb_drain", {30'd0, outstanding}, 32'd0);

        // Halfword store at offset 2
        drive(3'd0 == 3'd0 ? 5'd0 : 5'd0, ST_H, 32'h0000_2002, 32'h1234_ABCD);
        #1;
        check("sth_wstrb", {28'd0, sram_if.wstrb}, 32'h0000_000C);
        check("sth_wdata", sram_if.wdata, 32'hABCD_ABCD);
        check("sth_size", {30'd0, sram_if.size}, 32'd1);
        check("sth_wr", {31'd0, sram_if.wr}, 32'd1);
        check("sth_rg_wait", {31'd0, ready_go}, 32'd0);
        sram_if.addr_ok = 1'b1; #1;
        check("sth_rg_ok", {31'd0, ready_go}, 32'd1);
        tick();
        idle(); sram_if.addr_ok = 1'b0;
        sram_if.data_ok = 1'b1; sram_if.rdata = 32'hFFFF_FFFF; #1;
        check("sth_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("sth_resp_store", {31'd0, resp_is_store}, 32'd1);
        check("sth_resp_data", resp_data, 32'h0);
        tick();
        sram_if.data_ok = 1'b0;

        // Misaligned word load, plus byte-store lane decode
        drive(LD_W, 3'd0, 32'h0000_3001, 32'h0);
        #1;
        check("ale_flag", {31'd0, ale}, 32'd1);
        check("ale_req", {31'd0, sram_if.req}, 32'd0);
        check("ale_rg", {31'd0, ready_go}, 32'd1);
        check("ale_outstanding", {30'd0, outstanding}, 32'd0);
        drive(5'd0, ST_B, 32'h0000_3001, 32'h1234_ABCD);
        #1;
        check("stb_wstrb", {28'd0, sram_if.wstrb}, 32'h0000_0002);
        check("stb_wdata", sram_if.wdata, 32'hCDCD_CDCD);
        tick();

        // Fill both slots, third stalls, then issues alongside the first response
        drive(LD_W, 3'd0, 32'h0000_4000, 32'h0);
        sram_if.addr_ok = 1'b1; #1;
        check("fill1_req", {31'd0, sram_if.req}, 32'd1);
        tick();
        drive(LD_BU, 3'd0, 32'h0000_4001, 32'h0); #1;
        check("fill2_req", {31'd0, sram_if.req}, 32'd1);
        tick();
        drive(LD_HU, 3'd0, 32'h0000_4002, 32'h0); #1;
        check("full_req", {31'd0, sram_if.req}, 32'd0);
        check("full_rg", {31'd0, ready_go}, 32'd0);
        check("full_outstanding", {30'd0, outstanding}, 32'd2);
        tick();
        check("full_rg_hold", {31'd0, ready_go}, 32'd0);
        sram_if.data_ok = 1'b1; sram_if.rdata = 32'hDEAD_BEEF; #1;
        check("full_pop_data", resp_data, 32'hDEAD_BEEF);
        check("full_pop_valid", {31'd0, resp_valid}, 32'd1);
        check("full_refill_req", {31'd0, sram_if.req}, 32'd1);
        check("full_refill_rg", {31'd0, ready_go}, 32'd1);
        tick();
        idle(); sram_if.addr_ok = 1'b0; sram_if.rdata = 32'h0000_9A00; #1;
        check("pushpop_outstanding", {30'd0, outstanding}, 32'd2);
        check("ldbu_data", resp_data, 32'h0000_009A);
        tick();
        sram_if.rdata = 32'hF00D_0000; #1;
        check("ldhu_data", resp_data, 32'h0000_F00D);
        tick();
        sram_if.data_ok = 1'b0; #1;
        check("fill_drain", {30'd0, outstanding}, 32'd0);

        // Flush discards both outstanding responses
        drive(LD_W, 3'd0, 32'h0000_5000, 32'h0);
        sram_if.addr_ok = 1'b1;
        tick(); tick();
        idle(); sram_if.addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; sram_if.data_ok = 1'b1; sram_if.rdata = 32'h1111_1111; #1;
        check("flush_resp0", {31'd0, resp_valid}, 32'd0);
        tick();
        check("flush_resp1", {31'd0, resp_valid}, 32'd0);
        tick();
        sram_if.data_ok = 1'b0; #1;
        check("flush_drain", {30'd0, outstanding}, 32'd0);
        drive(LD_B, 3'd0, 32'h0000_6000, 32'h0);
        sram_if.addr_ok = 1'b1;
        tick();
        idle(); sram_if.addr_ok = 1'b0;
        sram_if.data_ok = 1'b1; sram_if.rdata = 32'h0000_007F; #1;
        check("post_flush_valid", {31'd0, resp_valid}, 32'd1);
        check("post_flush_data", resp_data, 32'h0000_007F);
        tick();
        sram_if.data_ok = 1'b0;

        // Flush coinciding with a push, and with a pop
        drive(LD_H, 3'd0, 32'h0000_6102, 32'h0);
        sram_if.addr_ok = 1'b1; flush = 1'b1;
        tick();
        idle(); sram_if.addr_ok = 1'b0; flush = 1'b0;
        sram_if.data_ok = 1'b1; sram_if.rdata = 32'h8001_1234; #1;
        check("flush_push_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        sram_if.data_ok = 1'b0;
        drive(LD_H, 3'd0, 32'h0000_6202, 32'h0);
        sram_if.addr_ok = 1'b1;
        tick();
        idle(); sram_if.addr_ok = 1'b0;
        sram_if.data_ok = 1'b1; #1;
        check("ldh_data", resp_data, 32'hFFFF_8001);
        flush = 1'b1; #1;
        check("flush_pop_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        flush = 1'b0; sram_if.data_ok = 1'b0; #1;
        check("flush_pop_drain", {30'd0, outstanding}, 32'd0);

        // Cancel while stalled holds the request off until handoff
        drive(LD_W, 3'd0, 32'h0000_7000, 32'h0);
        out_allow_in = 1'b0; cancel = 1'b1; #1;
        check("cancel_req", {31'd0, sram_if.req}, 32'd0);
        tick();
        cancel = 1'b0; out_allow_in = 1'b1; #1;
        check("hold_req", {31'd0, sram_if.req}, 32'd0);
        check("hold_rg", {31'd0, ready_go}, 32'd1);
        tick();
        check("after_handoff_req", {31'd0, sram_if.req}, 32'd1);
        idle();

        // Reset mid-transaction drops the entry; a later response is a protocol error
        drive(LD_W, 3'd0, 32'h0000_7100, 32'h0);
        sram_if.addr_ok = 1'b1;
        tick();
        idle(); sram_if.addr_ok = 1'b0; #1;
        check("pre_rst_outstanding", {30'd0, outstanding}, 32'd1);
        resetn = 1'b0; #1;
        check("async_rst_outstanding", {30'd0, outstanding}, 32'd0);
        tick();
        resetn = 1'b1;
        sram_if.data_ok = 1'b1; #1;
        check("orphan_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        sram_if.data_ok = 1'b0; #1;
        check("proto_err_set", {31'd0, proto_err}, 32'd1);
        check("orphan_outstanding", {30'd0, outstanding}, 32'd0);
        tick();
        check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
